// File: rtl/ex_alu_unit.sv
// Execute-stage ALU: single-cycle ops registered in one edge, MUL via an
// iterative 32-step shift-add multiplier that stalls upstream while busy.
module ex_alu_unit #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               valid_i,
    input  logic               flush_i,
    input  logic [4:0]         ALUCtrl_i,
    input  logic [DATA_W-1:0]  src1_i,
    input  logic [DATA_W-1:0]  src2_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    output logic [DATA_W-1:0]  result_o,
    output logic               zero_o,
    output logic               valid_o,
    output logic               stall_o
);

    localparam logic [4:0] OP_AND  = 5'b00000;
    localparam logic [4:0] OP_OR   = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00010;
    localparam logic [4:0] OP_MUL  = 5'b00011;
    localparam logic [4:0] OP_SLL  = 5'b00101;
    localparam logic [4:0] OP_SUB  = 5'b00110;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_ORI  = 5'b01100;
    localparam logic [4:0] OP_LUI  = 5'b01101;
    localparam logic [4:0] OP_BNE  = 5'b01110;
    localparam logic [4:0] OP_SRL  = 5'b01111;
    localparam logic [4:0] OP_JR   = 5'b10001;
    localparam logic [4:0] OP_JUMP = 5'b10100;
    localparam logic [4:0] OP_BGT  = 5'b10101;
    localparam logic [4:0] OP_BNEZ = 5'b10110;
    localparam logic [4:0] OP_BGEZ = 5'b10111;
    localparam logic [4:0] OP_JAL  = 5'b11000;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   mcand_q, mplier_q, acc_q;
    logic [DATA_W-1:0]   acc_next;
    logic [SHAMT_W-1:0]  count_q;
    logic [DATA_W-1:0]   alu_res;
    logic                start_mul;
    logic                last_step;

    assign start_mul = valid_i && (ALUCtrl_i == OP_MUL);
    assign last_step = (count_q == '1);
    assign acc_next  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    // Single-cycle operation decode (wrap-around arithmetic)
    always_comb begin
        alu_res = '0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            OP_SLL:  alu_res = src2_i << shamt_i;
            OP_SRL:  alu_res = src2_i >> shamt_i;
            OP_LUI:  alu_res = {src2_i[15:0], 16'b0};
            OP_ORI:  alu_res = src1_i | {16'b0, src2_i[15:0]};
            OP_BNE:  alu_res = src1_i - src2_i;
            OP_BGT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) > $signed(src2_i))};
            OP_BNEZ: alu_res = src1_i;
            OP_BGEZ: alu_res = {{(DATA_W-1){1'b0}}, ~src1_i[DATA_W-1]};
            OP_JR:   alu_res = src1_i;
            OP_JUMP: alu_res = src1_i;
            OP_JAL:  alu_res = src2_i;
            default: alu_res = '0;
        endcase
    end

    // Next-state logic; flush always returns to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_mul) state_d = S_MUL;
            S_MUL:   if (last_step) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush_i) state_d = S_IDLE;
    end

    // Upstream must hold ID/EX while a MUL is being accepted or iterating
    always_comb begin
        stall_o = !flush_i && (((state_q == S_IDLE) && start_mul) || (state_q == S_MUL));
    end

    // State, multiplier datapath and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_o <= '0;
            zero_o   <= 1'b0;
            valid_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (flush_i) begin
                count_q <= '0;
                valid_o <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start_mul) begin
                            mcand_q  <= src1_i;
                            mplier_q <= src2_i;
                            acc_q    <= '0;
                            count_q  <= '0;
                            valid_o  <= 1'b0;
                        end else if (valid_i) begin
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            valid_o  <= 1'b1;
                        end else begin
                            valid_o  <= 1'b0;
                        end
                    end
                    S_MUL: begin
                        acc_q    <= acc_next;
                        mcand_q  <= mcand_q << 1;
                        mplier_q <= mplier_q >> 1;
                        count_q  <= count_q + 1'b1;
                        // The final step's sum goes straight to the output
                        if (last_step) begin
                            result_o <= acc_next;
                            zero_o   <= (acc_next == '0);
                            valid_o  <= 1'b1;
                        end
                    end
                    default: begin
                        valid_o <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ex_alu_unit.sv
// Directed self-checking bench for ex_alu_unit.
module tb_ex_alu_unit;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        valid_i;
    logic        flush_i;
    logic [4:0]  ALUCtrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic [4:0]  shamt_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        valid_o;
    logic        stall_o;

    int checks   = 0;
    int failures = 0;

    ex_alu_unit #(.DATA_W(32), .SHAMT_W(5)) dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .flush_i   (flush_i),
        .ALUCtrl_i (ALUCtrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .shamt_i   (shamt_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .valid_o   (valid_o),
        .stall_o   (stall_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a single-cycle op at a negedge, check outputs after the next edge
    task automatic alu_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] sh, input logic [31:0] exp);
        valid_i   = 1'b1;
        ALUCtrl_i = op;
        src1_i    = a;
        src2_i    = b;
        shamt_i   = sh;
        @(negedge clk_i);
        chk({tag, "_valid"}, {31'b0, valid_o}, 32'd1);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_zero"}, {31'b0, zero_o}, {31'b0, (exp == 32'd0)});
    endtask

    // Full MUL: stall high for 33 sampled cycles, one-cycle valid pulse after E32
    task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp);
        int n;
        int n_stall;
        n = 0;
        n_stall = 0;
        valid_i   = 1'b1;
        ALUCtrl_i = 5'b00011;
        src1_i    = a;
        src2_i    = b;
        #1;
        if (stall_o) n_stall++;
        do begin
            @(negedge clk_i);
            n++;
            if (stall_o) n_stall++;
        end while (!valid_o && n < 100);
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_stall_cycles"}, n_stall, 33);
        chk({tag, "_res"}, result_o, exp);
        chk({tag, "_zero"}, {31'b0, zero_o}, {31'b0, (exp == 32'd0)});
        valid_i = 1'b0;
        @(negedge clk_i);
        chk({tag, "_pulse_end"}, {31'b0, valid_o}, 32'd0);
        chk({tag, "_hold"}, result_o, exp);
    endtask

    initial begin
        int pidx[3];
        logic [31:0] pval[3];
        int np;
        int extra;

        rst_i     = 1'b0;
        valid_i   = 1'b0;
        flush_i   = 1'b0;
        ALUCtrl_i = '0;
        src1_i    = '0;
        src2_i    = '0;
        shamt_i   = '0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk("rst_result", result_o, 32'd0);
        chk("rst_zero", {31'b0, zero_o}, 32'd0);
        chk("rst_valid", {31'b0, valid_o}, 32'd0);
        chk("rst_stall", {31'b0, stall_o}, 32'd0);
        rst_i = 1'b1;

        // ALU sweep
        alu_op("add",  5'b00010, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'h0000_0001);
        alu_op("sub",  5'b00110, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'hFFFF_FFFB);
        alu_op("slt",  5'b00111, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'h1);
        alu_op("sll",  5'b00101, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'h30);
        alu_op("lui",  5'b01101, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'h0003_0000);
        alu_op("bgez", 5'b10111, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'h0);
        alu_op("and",  5'b00000, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'h2);
        alu_op("or",   5'b00001, 32'hFFFF_FFFE, 32'h3, 5'd4, 32'hFFFF_FFFF);
        alu_op("srl",  5'b01111, 32'h1234_5678, 32'h8000_0000, 5'd4, 32'h0800_0000);
        alu_op("ori",  5'b01100, 32'h00F0_0000, 32'hABCD_1234, 5'd0, 32'h00F0_1234);
        alu_op("bgt",  5'b10101, 32'h0000_0005, 32'hFFFF_FFFF, 5'd0, 32'h1);
        alu_op("bgt_n",5'b10101, 32'hFFFF_FFFE, 32'h3, 5'd0, 32'h0);
        alu_op("bnez", 5'b10110, 32'hDEAD_BEEF, 32'h3, 5'd0, 32'hDEAD_BEEF);
        alu_op("jal",  5'b11000, 32'hDEAD_BEEF, 32'h0040_0008, 5'd0, 32'h0040_0008);
        alu_op("undef",5'b01000, 32'hDEAD_BEEF, 32'h3, 5'd0, 32'h0);
        alu_op("bne",  5'b01110, 32'h10, 32'h4, 5'd0, 32'hC);
        alu_op("add_z",5'b00010, 32'hFFFF_FFFE, 32'h2, 5'd4, 32'h0);
        alu_op("jr",   5'b10001, 32'h0000_1000, 32'h3, 5'd0, 32'h0000_1000);

        // Bubble: valid_o drops, result holds
        valid_i   = 1'b0;
        ALUCtrl_i = 5'b00010;
        src1_i    = 32'h5;
        @(negedge clk_i);
        chk("bubble_valid", {31'b0, valid_o}, 32'd0);
        chk("bubble_hold", result_o, 32'h0000_1000);

        // Multiplies
        run_mul("mul_a", 32'h0001_0003, 32'h5, 32'h0005_000F);
        run_mul("mul_neg", 32'hFFFF_FFF9, 32'h6, 32'hFFFF_FFD6);
        run_mul("mul_ovf", 32'h8000_0000, 32'h2, 32'h0);

        // Overflowing add wraps
        alu_op("add_ovf", 5'b00010, 32'h7FFF_FFFF, 32'h1, 5'd0, 32'h8000_0000);

        // Flush at count 15
        valid_i   = 1'b1;
        ALUCtrl_i = 5'b00011;
        src1_i    = 32'h7;
        src2_i    = 32'h9;
        repeat (16) @(negedge clk_i);
        chk("flush_pre_stall", {31'b0, stall_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        chk("flush_stall_drop", {31'b0, stall_o}, 32'd0);
        @(negedge clk_i);
        chk("flush_valid", {31'b0, valid_o}, 32'd0);
        chk("flush_hold", result_o, 32'h8000_0000);
        flush_i = 1'b0;
        alu_op("flush_add", 5'b00010, 32'h2, 32'h3, 5'd0, 32'h5);
        valid_i = 1'b0;
        extra = 0;
        repeat (40) begin
            @(negedge clk_i);
            if (valid_o) extra++;
        end
        chk("flush_no_late_result", extra, 0);

        // Reset mid-MUL at count 10
        valid_i   = 1'b1;
        ALUCtrl_i = 5'b00011;
        src1_i    = 32'h3;
        src2_i    = 32'h3;
        repeat (11) @(negedge clk_i);
        rst_i   = 1'b0;
        valid_i = 1'b0;
        repeat (2) @(negedge clk_i);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_valid", {31'b0, valid_o}, 32'd0);
        chk("midrst_stall", {31'b0, stall_o}, 32'd0);
        rst_i = 1'b1;
        run_mul("mul_after_rst", 32'h0000_1234, 32'h0000_0100, 32'h0012_3400);

        // Back-to-back MUL, MUL, ADD with upstream advancing only when not stalled
        np = 0;
        valid_i   = 1'b1;
        ALUCtrl_i = 5'b00011;
        src1_i    = 32'h3;
        src2_i    = 32'h5;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk_i);
            if (valid_o) begin
                if (np < 3) begin
                    pidx[np] = i;
                    pval[np] = result_o;
                end
                np++;
                if (np == 2) begin
                    ALUCtrl_i = 5'b00010;
                    src1_i    = 32'd10;
                    src2_i    = 32'd20;
                end else if (np == 3) begin
                    valid_i = 1'b0;
                end
            end
        end
        chk("b2b_pulses", np, 3);
        if (np >= 3) begin
            chk("b2b_p1_idx", pidx[0], 33);
            chk("b2b_p2_idx", pidx[1], 67);
            chk("b2b_add_idx", pidx[2], 69);
            chk("b2b_p1_val", pval[0], 32'd15);
            chk("b2b_p2_val", pval[1], 32'd15);
            chk("b2b_add_val", pval[2], 32'd30);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_alu_unit.md
Name: ex_alu_unit

Overview:
- Execute-stage ALU in the pipelined CPU, directly downstream of the ALU controller; consumes its 5-bit ALUCtrl code plus ID/EX operands.
- Produces a registered result and zero flag for the EX/MEM register.
- Single-cycle ops complete in one clock. MUL runs on an iterative 32-step shift-add multiplier that stalls the upstream pipeline while busy.

Parameters:
- DATA_W, 32, operand/result width; only 32 supported.
- SHAMT_W, 5, shift-amount width; equals log2(DATA_W).

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- valid_i  in  1  ID/EX holds a live instruction.
- flush_i  in  1  synchronous kill of current/in-flight op.
- ALUCtrl_i  in  5  operation code from ALU controller.
- src1_i  in  DATA_W  rs operand.
- src2_i  in  DATA_W  rt / immediate operand (already extended upstream).
- shamt_i  in  SHAMT_W  shift amount.
- result_o  out  DATA_W  registered result.
- zero_o  out  1  registered (result == 0).
- valid_o  out  1  result_o/zero_o carry a live instruction this cycle.
- stall_o  out  1  combinational; upstream must hold ID/EX when high.

Behaviour:
- Reset (rst_i == 0 at edge): result_o = 0, zero_o = 0, valid_o = 0, state = IDLE, iteration counter = 0, multiplier registers = 0. Reset overrides flush_i and an in-flight MUL.
- Op decode (32-bit wrap-around arithmetic, no overflow trap):
  - 00000 AND, 00001 OR, 00010 ADD, 00110 SUB.
  - 00111 SLT: signed compare; result 1 or 0.
  - 00101 SLL: src2 << shamt_i.
  - 01111 SRL: logical right shift, src2 >> shamt_i.
  - 01101 LUI: src2[15:0] << 16.
  - 01100 ORI: src1 | {16'b0, src2[15:0]}.
  - 01110 BNE: src1 - src2.
  - 10101 BGT: signed src1 > src2, result 1 or 0.
  - 10110 BNEZ: src1.
  - 10111 BGEZ: 1 if src1[31] == 0, else 0.
  - 10001 JR and 10100 JUMP: src1.
  - 11000 JAL: src2 (link address supplied upstream).
  - 00011 MUL: low 32 bits of the product.
  - Any other code: result 0.
- Single-cycle ops: at edge with valid_i = 1 and state IDLE, result_o and zero_o take the new values and valid_o goes to 1. With valid_i = 0, valid_o goes to 0 and result_o/zero_o hold.
- FSM states: IDLE, MUL, DONE.
  - IDLE -> MUL: valid_i and ALUCtrl_i == 00011 and no flush_i. Latch multiplicand = src1, multiplier = src2, accumulator = 0, count = 0. valid_o <= 0.
  - MUL: each edge, if multiplier[0] add multiplicand to accumulator; multiplicand <<= 1; multiplier >>= 1; count++. Input ports ignored.
  - MUL -> DONE: at the edge where count == 31, after the final step. result_o <= accumulator, zero_o <= (accumulator == 0), valid_o <= 1.
  - DONE -> IDLE: next edge, unconditionally; valid_o <= 0. The still-presented MUL instruction is NOT re-accepted.
- Latency: single-cycle ops 1 edge. MUL presented at edge E0 gives valid_o high for exactly the cycle after E32.
- stall_o = !flush_i && ((state == IDLE && valid_i && ALUCtrl_i == 00011) || state == MUL). stall_o is 0 in DONE, so upstream advances at the end of DONE.
- flush_i (edge, rst_i high): state <= IDLE, count <= 0, valid_o <= 0, result_o holds. Flush wins over a simultaneous MUL start or completion.
- Back-to-back MULs: second MUL presented during DONE is ignored there and accepted in the following IDLE cycle.

Test Plan:
- Reset: drive rst_i = 0 for 2 edges mid-MUL (count = 10) -> result_o = 0, valid_o = 0, stall_o = 0, state IDLE; next MUL runs full 32 steps.
- ALU sweep: src1 = 0xFFFF_FFFE, src2 = 0x0000_0003, shamt 4.
  - ADD -> 0x0000_0001
  - SUB -> 0xFFFF_FFFB
  - SLT -> 1
  - SLL -> 0x30
  - LUI -> 0x0003_0000
  - BGEZ -> 0
  - each valid_o one edge later; ADD with src2 = 2 -> zero_o = 1.
- MUL: 0x0001_0003 * 0x0000_0005 -> stall_o high 33 cycles (E0..E32), valid_o pulse after E32 with 0x0005_000F; MUL -7 * 6 -> 0xFFFF_FFD6.
- Overflow: MUL 0x8000_0000 * 2 -> result 0, zero_o = 1; ADD 0x7FFF_FFFF + 1 -> 0x8000_0000.
- Flush: flush_i at count 15 -> valid_o stays 0, stall_o drops same cycle, state IDLE; following ADD 2 + 3 -> 5 after 1 edge.
- Back-to-back: MUL, MUL, ADD with held inputs -> exactly two MUL valid_o pulses 34 cycles apart, then ADD one edge after second DONE, no duplicate results.
